// File: rtl/id_fifo_stage.sv
// Decode stage with an instruction buffer: fetch pushes {inst, pc}, the head is decoded
// combinationally and issued into a registered ex-facing slot. Define ID_LOAD_USE_EN for load-use interlock.
module id_fifo_stage #(
   parameter int DEPTH          = 4,
   parameter int ALMOST_FULL_TH = DEPTH - 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_i,
   input  logic [31:0] inst_addr_i,
   input  logic        inst_valid_i,
   output logic        inst_ready_o,
   output logic        inst_afull_o,
   input  logic        ex_jump_flag_i,
   output logic [4:0]  reg1_raddr_o,
   output logic [4:0]  reg2_raddr_o,
   input  logic [31:0] reg1_rdata_i,
   input  logic [31:0] reg2_rdata_i,
   output logic [31:0] csr_raddr_o,
   input  logic [31:0] csr_rdata_i,
   output logic [31:0] op1_o,
   output logic [31:0] op2_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        reg_we_o,
   output logic [4:0]  reg_waddr_o,
   output logic        csr_we_o,
   output logic [31:0] csr_rdata_o,
   output logic [31:0] csr_waddr_o,
   output logic [2:0]  compare_o,
   output logic [31:0] store_data_o,
   output logic        id_valid_o,
   input  logic        ex_ready_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] AFULL_TH = CW'(ALMOST_FULL_TH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   localparam logic WE = 1'b1;
   localparam logic WD = 1'b0;

   localparam logic [6:0] OP_L     = 7'b0000011;
   localparam logic [6:0] OP_CUST  = 7'b0001011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_RM    = 7'b0110011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_CSR   = 7'b1110011;

   // ---------------- instruction buffer ----------------
   logic [31:0]   mem_inst [DEPTH];
   logic [31:0]   mem_addr [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic          empty, full, push, issue, stall;

   assign empty        = (count == '0);
   assign full         = (count == FULL_CNT);
   assign inst_ready_o = !full;
   assign inst_afull_o = (count >= AFULL_TH);
   assign push         = inst_valid_i && inst_ready_o && !ex_jump_flag_i;
   assign issue        = !empty && (!id_valid_o || ex_ready_i) && !stall && !ex_jump_flag_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (ex_jump_flag_i) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)  wptr <= wptr + AW'(1);
         if (issue) rptr <= rptr + AW'(1);
         if (push && !issue)
            count <= count + CW'(1);
         else if (!push && issue)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_inst[wptr] <= inst_i;
         mem_addr[wptr] <= inst_addr_i;
      end
   end

   // ---------------- head decode ----------------
   logic [31:0] h, hpc;
   logic [6:0]  opcode, f7;
   logic [2:0]  f3;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, csr_addr;

   assign h        = mem_inst[rptr];
   assign hpc      = mem_addr[rptr];
   assign opcode   = h[6:0];
   assign rd       = h[11:7];
   assign f3       = h[14:12];
   assign rs1      = h[19:15];
   assign rs2      = h[24:20];
   assign f7       = h[31:25];
   assign imm_i    = {{20{h[31]}}, h[31:20]};
   assign imm_s    = {{20{h[31]}}, h[31:25], h[11:7]};
   assign imm_b    = {{19{h[31]}}, h[31], h[7], h[30:25], h[11:8], 1'b0};
   assign imm_j    = {{11{h[31]}}, h[31], h[19:12], h[20], h[30:21], 1'b0};
   assign imm_u    = {h[31:12], 12'b0};
   assign csr_addr = {20'b0, h[31:20]};

   logic        d_use1, d_use2, d_use_csr, d_reg_we, d_csr_we;
   logic [4:0]  d_waddr;
   logic [31:0] d_op1, d_op2, d_store;

   always_comb begin
      d_use1    = 1'b0;
      d_use2    = 1'b0;
      d_use_csr = 1'b0;
      d_reg_we  = WD;
      d_csr_we  = WD;
      d_waddr   = '0;
      d_op1     = '0;
      d_op2     = '0;
      d_store   = '0;
      if (!empty) begin
         case (opcode)
            OP_I: begin
               // shift-immediates only legal with their fixed funct7 patterns
               if ((f3 == 3'b001) ? (f7 == 7'h00) :
                   (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1) begin
                  d_use1   = 1'b1;
                  d_reg_we = WE;
                  d_waddr  = rd;
                  d_op1    = reg1_rdata_i;
                  d_op2    = imm_i;
               end
            end
            OP_RM, OP_CUST: begin
               if (opcode == OP_CUST || f7 == 7'h00 || f7 == 7'h01 ||
                   (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
                  d_use1   = 1'b1;
                  d_use2   = 1'b1;
                  d_reg_we = WE;
                  d_waddr  = rd;
                  d_op1    = reg1_rdata_i;
                  d_op2    = reg2_rdata_i;
               end
            end
            OP_L: begin
               if (!(f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) begin
                  d_use1   = 1'b1;
                  d_reg_we = WE;
                  d_waddr  = rd;
                  d_op1    = reg1_rdata_i;
                  d_op2    = imm_i;
               end
            end
            OP_S: begin
               if (f3 <= 3'b010) begin
                  d_use1  = 1'b1;
                  d_use2  = 1'b1;
                  d_op1   = reg1_rdata_i;
                  d_op2   = imm_s;
                  d_store = reg2_rdata_i;
               end
            end
            OP_B: begin
               if (f3 != 3'b010 && f3 != 3'b011) begin
                  d_use1 = 1'b1;
                  d_use2 = 1'b1;
                  d_op1  = hpc;
                  d_op2  = imm_b;
               end
            end
            OP_JAL: begin
               d_reg_we = WE;
               d_waddr  = rd;
               d_op1    = hpc;
               d_op2    = imm_j;
            end
            OP_JALR: begin
               if (f3 == 3'b000) begin
                  d_use1   = 1'b1;
                  d_reg_we = WE;
                  d_waddr  = rd;
                  d_op1    = reg1_rdata_i;
                  d_op2    = imm_i;
               end
            end
            OP_LUI: begin
               d_reg_we = WE;
               d_waddr  = rd;
               d_op1    = imm_u;
            end
            OP_AUIPC: begin
               d_reg_we = WE;
               d_waddr  = rd;
               d_op1    = hpc;
               d_op2    = imm_u;
            end
            OP_CSR: begin
               // funct3 000/100 are system ops (ecall/ebreak/mret): no writes here
               if (f3[1:0] != 2'b00) begin
                  d_use_csr = 1'b1;
                  d_csr_we  = WE;
                  d_reg_we  = WE;
                  d_waddr   = rd;
                  d_use1    = !f3[2];
                  d_op1     = f3[2] ? {27'b0, rs1} : reg1_rdata_i;
               end
            end
            default: ;
         endcase
      end
   end

   assign reg1_raddr_o = d_use1    ? rs1      : 5'd0;
   assign reg2_raddr_o = d_use2    ? rs2      : 5'd0;
   assign csr_raddr_o  = d_use_csr ? csr_addr : 32'd0;

`ifdef ID_LOAD_USE_EN
   // load result is not available until after ex, so hold a dependent head back one slot
   assign stall = id_valid_o && (inst_o[6:0] == OP_L) && (reg_waddr_o != 5'd0) &&
                  ((d_use1 && rs1 == reg_waddr_o) || (d_use2 && rs2 == reg_waddr_o));
`else
   assign stall = 1'b0;
`endif

   // ---------------- ex-facing register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_valid_o   <= 1'b0;
         reg_we_o     <= WD;
         csr_we_o     <= WD;
         op1_o        <= '0;
         op2_o        <= '0;
         inst_o       <= '0;
         inst_addr_o  <= '0;
         reg_waddr_o  <= '0;
         csr_rdata_o  <= '0;
         csr_waddr_o  <= '0;
         compare_o    <= '0;
         store_data_o <= '0;
      end else if (ex_jump_flag_i) begin
         id_valid_o <= 1'b0;
         reg_we_o   <= WD;
         csr_we_o   <= WD;
      end else if (issue) begin
         id_valid_o   <= 1'b1;
         reg_we_o     <= d_reg_we;
         csr_we_o     <= d_csr_we;
         op1_o        <= d_op1;
         op2_o        <= d_op2;
         inst_o       <= h;
         inst_addr_o  <= hpc;
         reg_waddr_o  <= d_waddr;
         csr_rdata_o  <= d_use_csr ? csr_rdata_i : 32'd0;
         csr_waddr_o  <= d_use_csr ? csr_addr : 32'd0;
         compare_o    <= {$signed(reg1_rdata_i) >= $signed(reg2_rdata_i),
                          reg1_rdata_i >= reg2_rdata_i,
                          reg1_rdata_i == reg2_rdata_i};
         store_data_o <= d_store;
      end else if (ex_ready_i || !id_valid_o) begin
         id_valid_o <= 1'b0;
         reg_we_o   <= WD;
         csr_we_o   <= WD;
      end
   end

endmodule

// File: tb/tb_id_fifo_stage.sv
// Directed bench for id_fifo_stage: latency, backpressure, flush, load-use, compare, reset.
// Expectations for the load-use case follow ID_LOAD_USE_EN as compiled.
module tb_id_fifo_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst_i, inst_addr_i;
   logic        inst_valid_i, inst_ready_o, inst_afull_o, ex_jump_flag_i;
   logic [4:0]  reg1_raddr_o, reg2_raddr_o;
   logic [31:0] reg1_rdata_i, reg2_rdata_i, csr_raddr_o, csr_rdata_i;
   logic [31:0] op1_o, op2_o, inst_o, inst_addr_o;
   logic        reg_we_o, csr_we_o, id_valid_o, ex_ready_i;
   logic [4:0]  reg_waddr_o;
   logic [31:0] csr_rdata_o, csr_waddr_o, store_data_o;
   logic [2:0]  compare_o;

   logic [31:0] rf [32];
   int n_err = 0;
   int n_chk = 0;

   localparam logic [31:0] LW_X5   = 32'h00012283; // lw  x5,0(x2)
   localparam logic [31:0] ADD_X6  = 32'h00328333; // add x6,x5,x3
   localparam logic [31:0] SW_X3   = 32'h00312223; // sw  x3,4(x2)
   localparam logic [31:0] BEQ     = 32'h00208463; // beq x1,x2,+8
   localparam logic [31:0] LUI_X7  = 32'h123453B7; // lui x7,0x12345
   localparam logic [31:0] CSRRW   = 32'h30009273; // csrrw x4,0x300,x1
   localparam logic [31:0] BAD_OP  = 32'hFFFFFFFF;

   assign reg1_rdata_i = rf[reg1_raddr_o];
   assign reg2_rdata_i = rf[reg2_raddr_o];
   assign csr_rdata_i  = csr_raddr_o ^ 32'hA5A50000;

   id_fifo_stage dut (
      .clk(clk), .rst(rst),
      .inst_i(inst_i), .inst_addr_i(inst_addr_i), .inst_valid_i(inst_valid_i),
      .inst_ready_o(inst_ready_o), .inst_afull_o(inst_afull_o), .ex_jump_flag_i(ex_jump_flag_i),
      .reg1_raddr_o(reg1_raddr_o), .reg2_raddr_o(reg2_raddr_o),
      .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
      .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i),
      .op1_o(op1_o), .op2_o(op2_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
      .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .csr_we_o(csr_we_o),
      .csr_rdata_o(csr_rdata_o), .csr_waddr_o(csr_waddr_o), .compare_o(compare_o),
      .store_data_o(store_data_o), .id_valid_o(id_valid_o), .ex_ready_i(ex_ready_i)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
      inst_valid_i = 1'b1;
      inst_i       = ins;
      inst_addr_i  = pc;
   endtask

   task automatic idle();
      inst_valid_i = 1'b0;
   endtask

   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
      return {imm, 5'd0, 3'b000, rd, 7'b0010011};
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      rst = 1'b1; inst_i = '0; inst_addr_i = '0; inst_valid_i = 1'b0;
      ex_jump_flag_i = 1'b0; ex_ready_i = 1'b0;
      step(); step();
      chk("rst_valid", {31'd0, id_valid_o}, 32'd0);
      chk("rst_we",    {31'd0, reg_we_o},   32'd0);
      chk("rst_op1",   op1_o,               32'd0);
      chk("rst_afull", {31'd0, inst_afull_o}, 32'd0);
      rst = 1'b0;
      step();
      chk("rel_ready", {31'd0, inst_ready_o}, 32'd1);

      // addi x1,x0,5 into an empty buffer: visible at ex two edges after the push
      ex_ready_i = 1'b1;
      offer(addi(5'd1, 12'd5), 32'h100);
      step(); idle(); #1;
      chk("lat_c1_valid", {31'd0, id_valid_o}, 32'd0);
      step();
      chk("lat_c2_valid", {31'd0, id_valid_o}, 32'd1);
      chk("addi_op1",   op1_o,              32'd0);
      chk("addi_op2",   op2_o,              32'd5);
      chk("addi_waddr", {27'd0, reg_waddr_o}, 32'd1);
      chk("addi_we",    {31'd0, reg_we_o},  32'd1);
      chk("addi_pc",    inst_addr_o,        32'h100);
      step();
      chk("drain_valid", {31'd0, id_valid_o}, 32'd0);
      chk("drain_we",    {31'd0, reg_we_o},   32'd0);

      // backpressure: 6 offers, one lands in ex register, four buffered, one refused
      ex_ready_i = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         offer(addi(5'(k), 12'(k)), 32'h200 + 32'(4 * k));
         step();
         if (k == 3) chk("afull_at2", {31'd0, inst_afull_o}, 32'd0);
         if (k == 4) chk("afull_at3", {31'd0, inst_afull_o}, 32'd1);
      end
      offer(addi(5'd6, 12'd6), 32'h218); #1;
      chk("full_ready", {31'd0, inst_ready_o}, 32'd0);
      chk("full_afull", {31'd0, inst_afull_o}, 32'd1);
      chk("full_valid", {31'd0, id_valid_o},   32'd1);
      chk("full_head",  {27'd0, reg_waddr_o},  32'd1);
      step(); idle();
      ex_ready_i = 1'b1;
      for (int k = 2; k <= 5; k++) begin
         step();
         chk("order_waddr", {27'd0, reg_waddr_o}, 32'(k));
         chk("order_op2",   op2_o,                32'(k));
      end
      chk("after_ready", {31'd0, inst_ready_o}, 32'd1);
      step();
      chk("no_sixth", {31'd0, id_valid_o}, 32'd0);

      // flush with three buffered and a concurrent push
      ex_ready_i = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         offer(addi(5'(10 + k), 12'(k)), 32'h300 + 32'(4 * k));
         step();
      end
      offer(addi(5'd19, 12'd9), 32'h340);
      ex_jump_flag_i = 1'b1;
      step();
      ex_jump_flag_i = 1'b0; idle();
      chk("flush_valid", {31'd0, id_valid_o},   32'd0);
      chk("flush_ready", {31'd0, inst_ready_o}, 32'd1);
      chk("flush_afull", {31'd0, inst_afull_o}, 32'd0);
      chk("flush_r1",    {27'd0, reg1_raddr_o}, 32'd0);
      ex_ready_i = 1'b1;
      step(); step();
      chk("flush_empty", {31'd0, id_valid_o}, 32'd0);
      offer(addi(5'd20, 12'd20), 32'h400);
      step(); idle(); step();
      chk("post_flush_valid", {31'd0, id_valid_o},  32'd1);
      chk("post_flush_waddr", {27'd0, reg_waddr_o}, 32'd20);
      step();

      // load-use: lw x5 then add x6,x5,x3
      rf[2] = 32'h1000; rf[3] = 32'd7; rf[5] = 32'h20;
      offer(LW_X5, 32'h500);
      step();
      offer(ADD_X6, 32'h504);
      step(); idle(); #1;
      chk("lw_inst", inst_o, LW_X5);
      chk("lw_op1",  op1_o,  32'h1000);
      chk("lw_waddr", {27'd0, reg_waddr_o}, 32'd5);
      chk("add_rs2_addr", {27'd0, reg2_raddr_o}, 32'd3);
      step();
`ifdef ID_LOAD_USE_EN
      chk("lu_bubble", {31'd0, id_valid_o}, 32'd0);
      step();
`endif
      chk("add_valid", {31'd0, id_valid_o}, 32'd1);
      chk("add_inst",  inst_o, ADD_X6);
      chk("add_op1",   op1_o,  32'h20);
      chk("add_op2",   op2_o,  32'd7);

      offer(SW_X3, 32'h508);
      step(); idle(); step();
      chk("sw_op1",   op1_o,             32'h1000);
      chk("sw_op2",   op2_o,             32'd4);
      chk("sw_store", store_data_o,      32'd7);
      chk("sw_we",    {31'd0, reg_we_o}, 32'd0);

      // branch compare: x1=-1, x2=1
      rf[1] = 32'hFFFFFFFF; rf[2] = 32'd1;
      offer(BEQ, 32'h600);
      step(); idle(); step();
      chk("beq_cmp", {29'd0, compare_o}, 32'd2);
      chk("beq_op1", op1_o, 32'h600);
      chk("beq_op2", op2_o, 32'd8);

      offer(LUI_X7, 32'h604);
      step(); idle(); step();
      chk("lui_op1",   op1_o,              32'h12345000);
      chk("lui_waddr", {27'd0, reg_waddr_o}, 32'd7);

      offer(BAD_OP, 32'h608);
      step(); idle(); step();
      chk("bad_valid", {31'd0, id_valid_o}, 32'd1);
      chk("bad_we",    {31'd0, reg_we_o},   32'd0);
      chk("bad_op1",   op1_o,               32'd0);
      chk("bad_csrwe", {31'd0, csr_we_o},   32'd0);

      offer(CSRRW, 32'h60C);
      step(); idle(); step();
      chk("csr_we",    {31'd0, csr_we_o}, 32'd1);
      chk("csr_waddr", csr_waddr_o,       32'h300);
      chk("csr_rdata", csr_rdata_o,       32'hA5A50300);
      chk("csr_op1",   op1_o,             32'hFFFFFFFF);

      // reset mid-stream with a held instruction and buffered work
      ex_ready_i = 1'b0;
      offer(addi(5'd9, 12'd9), 32'h700); step();
      offer(addi(5'd8, 12'd8), 32'h704); step();
      offer(addi(5'd7, 12'd7), 32'h708); step();
      idle();
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, id_valid_o},   32'd0);
      chk("mid_rst_we",    {31'd0, reg_we_o},     32'd0);
      chk("mid_rst_op2",   op2_o,                 32'd0);
      chk("mid_rst_inst",  inst_o,                32'd0);
      chk("mid_rst_pc",    inst_addr_o,           32'd0);
      chk("mid_rst_waddr", {27'd0, reg_waddr_o},  32'd0);
      chk("mid_rst_ready", {31'd0, inst_ready_o}, 32'd1);
      step();
      rst = 1'b0;
      step();
      chk("post_rst_ready", {31'd0, inst_ready_o}, 32'd1);
      ex_ready_i = 1'b1;
      step(); step();
      chk("post_rst_empty", {31'd0, id_valid_o}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
